// File: rtl/boot_fetch.sv
// Serial program loader and instruction fetch front-end: loads a checksummed
// frame of 16-bit words into program memory, then runs a program counter over it.
module boot_fetch #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        boot_req,
    input  logic        boot_valid,
    input  logic [7:0]  boot_data,
    output logic        boot_ready,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [15:0] imem_wdata,
    input  logic [15:0] imem_rdata,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [11:0] pc_next,
    output logic [11:0] pc,
    output logic [15:0] instruction,
    output logic        bootstrapping,
    output logic        boot_err
);

    localparam logic [2:0] S_HDR_HI  = 3'd0;
    localparam logic [2:0] S_HDR_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_CKSUM   = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  sum_q, sum_d;
    logic [11:0] idx_q, idx_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  hdr_q, hdr_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] tmo_q, tmo_d;

    logic        loading;
    logic        accept;
    logic [15:0] tmo_inc;
    logic [11:0] frame_words;

    assign loading     = (state_q != S_RUN) && (state_q != S_ERROR);
    // A restart request swallows whatever byte is offered alongside it.
    assign accept      = boot_valid && loading && !boot_req;
    assign tmo_inc     = tmo_q + 16'd1;
    assign frame_words = {hdr_q, boot_data};

    assign boot_ready    = loading;
    assign imem_we       = (state_q == S_DATA_LO) && accept;
    assign imem_addr     = (state_q == S_RUN) ? pc_q : idx_q;
    assign imem_wdata    = {hi_q, boot_data};
    assign pc            = pc_q;
    assign instruction   = (state_q == S_RUN) ? imem_rdata : 16'h0000;
    assign bootstrapping = (state_q != S_RUN);
    assign boot_err      = (state_q == S_ERROR);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        hi_d    = hi_q;
        tmo_d   = tmo_q;

        if (boot_req) begin
            state_d = S_HDR_HI;
            pc_d    = 12'h000;
            sum_d   = 8'h00;
            idx_d   = 12'h000;
            tmo_d   = 16'h0000;
        end else begin
            case (state_q)
                S_HDR_HI: begin
                    if (accept) begin
                        sum_d = sum_q + boot_data;
                        hdr_d = boot_data[3:0];
                        state_d = (boot_data[7:4] != 4'h0) ? S_ERROR : S_HDR_LO;
                    end
                end
                S_HDR_LO, S_DATA_HI, S_DATA_LO, S_CKSUM: begin
                    if (accept) begin
                        tmo_d = 16'h0000;
                        if (state_q != S_CKSUM) begin
                            sum_d = sum_q + boot_data;
                        end
                        case (state_q)
                            S_HDR_LO: begin
                                cnt_d   = frame_words;
                                idx_d   = 12'h000;
                                state_d = (frame_words == 12'h000) ? S_CKSUM : S_DATA_HI;
                            end
                            S_DATA_HI: begin
                                hi_d    = boot_data;
                                state_d = S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                idx_d   = idx_q + 12'd1;
                                state_d = (idx_q + 12'd1 == cnt_q) ? S_CKSUM : S_DATA_HI;
                            end
                            default: begin
                                state_d = (boot_data == sum_q) ? S_RUN : S_ERROR;
                            end
                        endcase
                    end else if (tmo_inc == TIMEOUT) begin
                        tmo_d   = 16'h0000;
                        state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                S_RUN: begin
                    if (pc_load) begin
                        pc_d = pc_next;
                    end else if (pc_inc) begin
                        pc_d = pc_q + 12'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_HDR_HI;
            pc_q    <= 12'h000;
            sum_q   <= 8'h00;
            idx_q   <= 12'h000;
            cnt_q   <= 12'h000;
            hdr_q   <= 4'h0;
            hi_q    <= 8'h00;
            tmo_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            hi_q    <= hi_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
